// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: FSM state encoding, generator defaults
// and a helper for sizing small counters.
package prbs_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int         DEF_WIDTH       = 4;
    localparam logic [3:0] DEF_TAPS        = 4'b1100;
    localparam int         DEF_LOCK_CNT    = 8;
    localparam int         DEF_WINDOW      = 32;
    localparam int         DEF_UNLOCK_ERRS = 4;
    localparam int         DEF_CNT_W       = 16;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream input and status output bundle of the PRBS checker.
interface prbs_checker_if
    import prbs_checker_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             clr;
    logic             in_valid;
    logic             in_bit;
    logic             locked;
    logic             err_o;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic             stuck_zero;

    modport master (
        output clr, in_valid, in_bit,
        input  locked, err_o, err_count, bit_count, stuck_zero
    );

    modport slave (
        input  clr, in_valid, in_bit,
        output locked, err_o, err_count, bit_count, stuck_zero
    );

endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock detection and error counting.
// Optional build macro PRBS_CHK_AUTO_RESYNC_EN: drop lock after too many errors in a window.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEF_TAPS),
    parameter int               LOCK_CNT    = DEF_LOCK_CNT,
    parameter int               WINDOW      = DEF_WINDOW,
    parameter int               UNLOCK_ERRS = DEF_UNLOCK_ERRS,
    parameter int               CNT_W       = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int FILL_W  = cnt_width(WIDTH);
    localparam int MATCH_W = cnt_width(LOCK_CNT);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   hist_reg, hist_next;
    logic [FILL_W-1:0]  fill_cnt_reg, fill_cnt_next;
    logic [MATCH_W-1:0] match_cnt_reg, match_cnt_next;
    logic               stuck_zero_reg, stuck_zero_next;
    logic               err_reg, err_next;
    logic               pred;
    logic               mismatch;
    logic [1:0]         cnt_inc;
    logic [CNT_W-1:0]   cnt_val [2];

`ifdef PRBS_CHK_AUTO_RESYNC_EN
    localparam int WIN_W  = cnt_width(WINDOW);
    localparam int WERR_W = cnt_width(UNLOCK_ERRS);

    logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0] win_err_reg, win_err_next;
    logic [WERR_W:0]   win_err_sum;

    assign win_err_sum = {1'b0, win_err_reg} + (WERR_W + 1)'(mismatch);
`endif

    // Configurations outside these bounds have no meaningful behaviour.
    if (WIDTH < 2 || LOCK_CNT < 1 || WINDOW < 1 || UNLOCK_ERRS < 1) begin : g_cfg_unsupported
    end

    assign pred     = ^(hist_reg & TAPS);
    assign mismatch = bus.in_bit ^ pred;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= HUNT;
            hist_reg       <= '0;
            fill_cnt_reg   <= '0;
            match_cnt_reg  <= '0;
            stuck_zero_reg <= 1'b0;
            err_reg        <= 1'b0;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
            win_cnt_reg    <= '0;
            win_err_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            hist_reg       <= hist_next;
            fill_cnt_reg   <= fill_cnt_next;
            match_cnt_reg  <= match_cnt_next;
            stuck_zero_reg <= stuck_zero_next;
            err_reg        <= err_next;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
            win_cnt_reg    <= win_cnt_next;
            win_err_reg    <= win_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        hist_next       = hist_reg;
        fill_cnt_next   = fill_cnt_reg;
        match_cnt_next  = match_cnt_reg;
        stuck_zero_next = stuck_zero_reg;
        err_next        = 1'b0;
        cnt_inc         = 2'b00;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
        win_cnt_next    = win_cnt_reg;
        win_err_next    = win_err_reg;
`endif
        if (bus.clr) begin
            state_next      = HUNT;
            hist_next       = '0;
            fill_cnt_next   = '0;
            match_cnt_next  = '0;
            stuck_zero_next = 1'b0;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
            win_cnt_next    = '0;
            win_err_next    = '0;
`endif
        end else if (bus.in_valid) begin
            unique case (state_reg)
                HUNT: begin
                    hist_next = {hist_reg[WIDTH-2:0], bus.in_bit};
                    if (fill_cnt_reg == FILL_W'(WIDTH - 1)) begin
                        state_next     = SYNC;
                        fill_cnt_next  = '0;
                        match_cnt_next = '0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + FILL_W'(1);
                    end
                end

                SYNC: begin
                    // Received bits feed the history, so a correct stream self-aligns.
                    hist_next = {hist_reg[WIDTH-2:0], bus.in_bit};
                    if (hist_reg == '0) begin
                        stuck_zero_next = 1'b1;
                        match_cnt_next  = '0;
                    end else if (!mismatch) begin
                        if (match_cnt_reg == MATCH_W'(LOCK_CNT - 1)) begin
                            state_next     = LOCKED;
                            match_cnt_next = '0;
                        end else begin
                            match_cnt_next = match_cnt_reg + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_next = '0;
                    end
                end

                LOCKED: begin
                    // Free-run on the prediction so a corrupted bit cannot poison later checks.
                    hist_next  = {hist_reg[WIDTH-2:0], pred};
                    cnt_inc[1] = 1'b1;
                    if (mismatch) begin
                        err_next   = 1'b1;
                        cnt_inc[0] = 1'b1;
                    end
`ifdef PRBS_CHK_AUTO_RESYNC_EN
                    if (win_err_sum >= (WERR_W + 1)'(UNLOCK_ERRS)) begin
                        state_next    = HUNT;
                        hist_next     = '0;
                        fill_cnt_next = '0;
                        win_cnt_next  = '0;
                        win_err_next  = '0;
                    end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        win_err_next = win_err_sum[WERR_W-1:0];
                    end
`endif
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // Index 0 counts errors, index 1 counts checked bits.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (bus.clr),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.locked     = (state_reg == LOCKED);
    assign bus.err_o      = err_reg;
    assign bus.stuck_zero = stuck_zero_reg;
    assign bus.err_count  = cnt_val[0];
    assign bus.bit_count  = cnt_val[1];

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: directed bring-up scenarios followed by randomized
// traffic, checked against a queue-based behavioural model of the checker.
module tb_prbs_checker;

    localparam int W      = 4;
    localparam int LOCK_N = 8;
    localparam int WIN    = 32;
    localparam int UNLK   = 4;
    localparam int CW     = 8;
    localparam int MAXC   = (1 << CW) - 1;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    localparam int M_HUNT   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(CW)) bus ();

    prbs_checker #(
        .WIDTH       (W),
        .TAPS        (4'b1100),
        .LOCK_CNT    (LOCK_N),
        .WINDOW      (WIN),
        .UNLOCK_ERRS (UNLK),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          locked;
        logic          err_o;
        logic [CW-1:0] errs;
        logic [CW-1:0] bits;
        logic          stuck;
    } status_t;

    status_t exp_q[$];
    int      vectors     = 0;
    int      miscompares = 0;

    // Reference stream of the generator seeded with 4'b0001.
    bit       seq[15];
    int       ph = 0;
    bit [3:0] taps_m = 4'b1100;

    // Behavioural model state.
    int m_mode;
    bit m_hist[$];
    int m_run, m_errs, m_bits, m_wbits, m_werrs;
    bit m_stuck, m_err;

    function automatic bit nb();
        bit b;
        b  = seq[ph];
        ph = (ph + 1) % 15;
        return b;
    endfunction

    function automatic void model_clear();
        m_mode  = M_HUNT;
        m_hist.delete();
        m_run   = 0;
        m_errs  = 0;
        m_bits  = 0;
        m_wbits = 0;
        m_werrs = 0;
        m_stuck = 1'b0;
        m_err   = 1'b0;
    endfunction

    // Next bit of x^4+x^3+1 from the last W bits (queue back = newest).
    function automatic bit model_pred();
        bit p;
        p = 1'b0;
        for (int k = 0; k < W; k++)
            if (taps_m[k]) p ^= m_hist[m_hist.size() - 1 - k];
        return p;
    endfunction

    function automatic void model_step(input bit c, input bit v, input bit b);
        bit zero, p;
        m_err = 1'b0;
        if (c) begin
            model_clear();
            return;
        end
        if (!v) return;
        case (m_mode)
            M_HUNT: begin
                m_hist.push_back(b);
                if (m_hist.size() == W) begin
                    m_mode = M_SYNC;
                    m_run  = 0;
                end
            end
            M_SYNC: begin
                zero = 1'b1;
                foreach (m_hist[k]) if (m_hist[k]) zero = 1'b0;
                p = model_pred();
                m_hist.push_back(b);
                void'(m_hist.pop_front());
                if (zero) begin
                    m_stuck = 1'b1;
                    m_run   = 0;
                end else if (b == p) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_mode = M_LOCKED;
                        m_run  = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            default: begin
                p = model_pred();
                m_hist.push_back(p);
                void'(m_hist.pop_front());
                m_bits = (m_bits < MAXC) ? m_bits + 1 : MAXC;
                if (b != p) begin
                    m_err  = 1'b1;
                    m_errs = (m_errs < MAXC) ? m_errs + 1 : MAXC;
                end
                if (RESYNC) begin
                    m_wbits++;
                    if (b != p) m_werrs++;
                    if (m_werrs >= UNLK) begin
                        m_mode = M_HUNT;
                        m_hist.delete();
                        m_wbits = 0;
                        m_werrs = 0;
                    end else if (m_wbits == WIN) begin
                        m_wbits = 0;
                        m_werrs = 0;
                    end
                end
            end
        endcase
    endfunction

    task automatic apply(input bit c, input bit v, input bit b);
        status_t e;
        @(negedge clk);
        #1;
        bus.clr      = c;
        bus.in_valid = v;
        bus.in_bit   = b;
        @(posedge clk);
        model_step(c, v, b);
        e.locked = (m_mode == M_LOCKED);
        e.err_o  = m_err;
        e.errs   = CW'(m_errs);
        e.bits   = CW'(m_bits);
        e.stuck  = m_stuck;
        exp_q.push_back(e);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b1, nb());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    // Monitor: every clocked transaction's status is compared half a cycle later.
    always @(negedge clk) begin
        status_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.locked = bus.locked;
            a.err_o  = bus.err_o;
            a.errs   = bus.err_count;
            a.bits   = bus.bit_count;
            a.stuck  = bus.stuck_zero;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL status vec %0d: got locked=%b err_o=%b err_count=%0d bit_count=%0d stuck=%b, expected locked=%b err_o=%b err_count=%0d bit_count=%0d stuck=%b",
                         vectors, a.locked, a.err_o, a.errs, a.bits, a.stuck,
                         e.locked, e.err_o, e.errs, e.bits, e.stuck);
            end else begin
                $display("vec %0d: locked=%b err_o=%b err_count=%0d bit_count=%0d stuck=%b",
                         vectors, a.locked, a.err_o, a.errs, a.bits, a.stuck);
            end
        end
    end

    initial begin
        bit b, v, c;
        seq = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        model_clear();
        #12;
        rst = 1'b0;
        #1;
        chk("reset_locked", bus.locked, 0);
        chk("reset_err_o", bus.err_o, 0);
        chk("reset_err_count", bus.err_count, 0);
        chk("reset_bit_count", bus.bit_count, 0);
        chk("reset_stuck", bus.stuck_zero, 0);

        // Clean stream locks after bit 12.
        clean(11);
        #1 chk("s1_prelock", bus.locked, 0);
        clean(1);
        #1 chk("s1_lock", bus.locked, 1);
        clean(8);
        #1 chk("s1_bit_count", bus.bit_count, 8);
        chk("s1_err_count", bus.err_count, 0);

        // Single inverted bit: one pulse, no propagation.
        b = nb();
        apply(1'b0, 1'b1, ~b);
        #1 chk("s2_err_pulse", bus.err_o, 1);
        chk("s2_err_count", bus.err_count, 1);
        clean(1);
        #1 chk("s2_err_single", bus.err_o, 0);
        clean(10);
        #1 chk("s2_no_propagation", bus.err_count, 1);
        chk("s2_still_locked", bus.locked, 1);

        // Four errors within one window.
        apply(1'b1, 1'b0, 1'b0);
        #1 chk("s3_clr_unlock", bus.locked, 0);
        clean(12);
        #1 chk("s3_relock", bus.locked, 1);
        for (int i = 0; i < 12; i++) begin
            b = nb();
            apply(1'b0, 1'b1, (i % 3 == 1) ? ~b : b);
            if (i == 10) begin
                #1 chk("s3_after_4th_err", bus.locked, RESYNC ? 0 : 1);
            end
        end
        #1 chk("s3_err_count", bus.err_count, 4);
        clean(10);
        #1 chk("s3_before_relock", bus.locked, RESYNC ? 0 : 1);
        clean(1);
        #1 chk("s3_relocked", bus.locked, 1);

        // All-zero input: sticky flag, no lock; clean stream relocks.
        apply(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, 1'b0);
        #1 chk("s4_stuck", bus.stuck_zero, 1);
        chk("s4_no_lock", bus.locked, 0);
        ph = 0;
        clean(11);
        #1 chk("s4_prelock", bus.locked, 0);
        clean(1);
        #1 chk("s4_lock", bus.locked, 1);
        chk("s4_stuck_kept", bus.stuck_zero, 1);

        // Alternating valid: idle cycles carry random data that must be ignored.
        apply(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            apply(1'b0, 1'b1, nb());
            if (k < 12) apply(1'b0, 1'b0, 1'($urandom));
            if (k == 11) begin
                #1 chk("s5_prelock", bus.locked, 0);
            end
        end
        #1 chk("s5_lock", bus.locked, 1);

        // clr together with in_valid while locked.
        clean(3);
        apply(1'b1, 1'b1, nb());
        #1 chk("s6_clr_locked", bus.locked, 0);
        chk("s6_clr_bit_count", bus.bit_count, 0);
        chk("s6_clr_err_count", bus.err_count, 0);

        // Async reset in SYNC clears outputs immediately.
        for (int i = 0; i < 6; i++) apply(1'b0, 1'b1, 1'b0);
        #1 chk("s6_sync_stuck", bus.stuck_zero, 1);
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("s6_rst_stuck", bus.stuck_zero, 0);
        chk("s6_rst_locked", bus.locked, 0);
        chk("s6_rst_err_o", bus.err_o, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        // Long clean run drives bit_count into saturation.
        clean(300);
        #1 chk("s7_bit_count_sat", bus.bit_count, MAXC);
        chk("s7_locked", bus.locked, 1);

        // Randomized traffic: gaps, bit errors, occasional clear.
        repeat (1000) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 299) == 0);
            if (v) begin
                b = nb();
                if ($urandom_range(0, 39) == 0) b = ~b;
            end else begin
                b = 1'($urandom);
            end
            apply(c, v, b);
        end

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
